cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Miss/refill sequencer for the 4-set direct-mapped data cache: 16-byte blocks, 4 words per block, address split tag[31:6] / set[5:4] / offset[3:2].
- Sits between the MEM stage and main memory. Looks up the cache, stalls the pipeline on a miss, fetches the 4-word block over a ready-handshake memory port, writes the block into the cache and returns the requested word.
- Stores are write-through, no-write-allocate; a store invalidates the addressed set.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 32, byte address width.
- CNT_WIDTH, 16, width of the hit/miss performance counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  MEM stage has an access; held stable while stall=1.
- req_we  in  1  1=store, 0=load.
- req_byte  in  1  load result is zero-extended byte [7:0].
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data.
- stall  out  1  freeze the pipeline.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_data  out  DATA_WIDTH  load data, valid with rsp_valid.
- cache_addr  out  ADDR_WIDTH  address driven to the cache (the captured request).
- cache_hit  in  1  cache hit flag, valid in the cycle after cache_addr is presented.
- cache_rdata  in  DATA_WIDTH  cache word/byte output, valid with cache_hit.
- fill_we  out  1  one-cycle pulse: write the block to the set of cache_addr.
- fill_d0..fill_d3  out  DATA_WIDTH each  block words at offsets 0..3.
- cache_inv  out  1  one-cycle pulse: clear the valid bit of the set of cache_addr.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  word-aligned memory address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_ready  in  1  beat accepted (write) or mem_rdata valid (read).
- mem_rdata  in  DATA_WIDTH  read data.
- hit_cnt  out  CNT_WIDTH  load hits, wraps.
- miss_cnt  out  CNT_WIDTH  load misses, wraps.

Behaviour:
- Reset values: state=IDLE, beat=0, block buffer=0, counters=0. All pulse and request outputs are 0: rsp_valid, fill_we, cache_inv, mem_req, mem_we. rsp_data=0.
- Combinational stall = (req_valid | state!=IDLE) & ~rsp_valid.
- IDLE:
  - On req_valid, capture addr, we, byte and wdata.
  - ->LOOKUP if load; ->WRITE if store.
- LOOKUP:
  - cache_hit=1: rsp_valid=1, rsp_data=cache_rdata, hit_cnt++, ->IDLE. Hit latency is 2 cycles from request acceptance to rsp_valid.
  - cache_hit=0: miss_cnt++, beat=0, ->REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={addr[31:4], beat, 2'b00}.
  - On mem_ready: buf[beat]=mem_rdata. If beat==3, ->FILL; else beat++.
  - Without mem_ready, hold mem_addr unchanged. Memory latency is unbounded.
- FILL:
  - fill_we=1 for exactly one cycle; fill_d0..d3=buf[0..3]; cache_addr = captured addr.
  - Same cycle: rsp_valid=1, rsp_data = buf[addr[3:2]], or {24'b0, buf[addr[3:2]][7:0]} if req_byte.
  - ->IDLE. Miss latency = 3 + sum of the 4 beat latencies.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr={addr[31:2], 2'b00}, mem_wdata = captured wdata.
  - On mem_ready: cache_inv=1 and rsp_valid=1 in the same cycle, ->IDLE.
- Request timing: in IDLE, a new request is accepted the cycle after rsp_valid. There is no back-to-back acceptance in the rsp_valid cycle.
- Invariants:
  - fill_we and cache_inv are never asserted in the same cycle.
  - mem_req is never asserted in IDLE, LOOKUP or FILL.
- Reset mid-operation: the next state is IDLE. Any partial refill is discarded (no fill_we), mem_req drops, and counters clear. The memory must tolerate an abandoned request.
- Counter wrap: counters wrap modulo 2^CNT_WIDTH (0xFFFF+1 -> 0x0000).
- Inputs ignored: req_* changes while stall=1 are ignored; the captured copy is used.

Test Plan:
- Cold load of 0x0000_0048, mem_ready every cycle, memory returns word index:
  - Required: 4 reads at 0x40, 0x44, 0x48, 0x4C.
  - Required: fill_we with d0..d3 = 0x10..0x13, rsp_data=0x12, miss_cnt=1, stall high for 7 cycles.
- Repeat load of 0x48 with cache_hit=1, cache_rdata=0x12 -> rsp_valid 2 cycles after acceptance, rsp_data=0x12, hit_cnt=1, no mem_req.
- Store 0xDEADBEEF to 0x44, mem_ready after 3 cycles:
  - Required: mem_we=1, mem_addr=0x44, mem_wdata=0xDEADBEEF held for 3 cycles.
  - Required: cache_inv and rsp_valid together, no fill_we.
- Byte load, miss at 0x4C, memory word 0x1234_56AB -> rsp_data=0x0000_00AB.
- rst asserted during beat 2 of a refill -> next cycle IDLE, mem_req=0, no fill_we ever, counters=0. A subsequent load restarts at beat 0.
- Preload miss_cnt=0xFFFF, then one miss -> miss_cnt=0x0000.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// rtl/cache_ctrl_if.sv - request, cache-port and memory-port bundle for the miss/refill sequencer
// master = sequencer side, slave = pipeline/cache/memory side.
interface cache_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  req_valid;
  logic                  req_we;
  logic                  req_byte;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  stall;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic [ADDR_WIDTH-1:0] cache_addr;
  logic                  cache_hit;
  logic [DATA_WIDTH-1:0] cache_rdata;
  logic                  fill_we;
  logic [DATA_WIDTH-1:0] fill_d0;
  logic [DATA_WIDTH-1:0] fill_d1;
  logic [DATA_WIDTH-1:0] fill_d2;
  logic [DATA_WIDTH-1:0] fill_d3;
  logic                  cache_inv;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic [CNT_WIDTH-1:0]  hit_cnt;
  logic [CNT_WIDTH-1:0]  miss_cnt;

  modport master (
    input  req_valid, req_we, req_byte, req_addr, req_wdata,
    input  cache_hit, cache_rdata, mem_ready, mem_rdata,
    output stall, rsp_valid, rsp_data,
    output cache_addr, fill_we, fill_d0, fill_d1, fill_d2, fill_d3, cache_inv,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output hit_cnt, miss_cnt
  );

  modport slave (
    output req_valid, req_we, req_byte, req_addr, req_wdata,
    output cache_hit, cache_rdata, mem_ready, mem_rdata,
    input  stall, rsp_valid, rsp_data,
    input  cache_addr, fill_we, fill_d0, fill_d1, fill_d2, fill_d3, cache_inv,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - miss/refill sequencer for the 4-set direct-mapped data cache
// Loads look up the cache and refill 4-word blocks on a miss; stores write through and invalidate the set.
module cache_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         rst,
  cache_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, FILL, WRITE} state_t;

  state_t                state;
  logic [1:0]            beat;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_byte;
  logic [DATA_WIDTH-1:0] blk [4];
  logic [DATA_WIDTH-1:0] sel_word;

  assign sel_word       = blk[cap_addr[3:2]];
  assign bus.stall      = (bus.req_valid | (state != IDLE)) & ~bus.rsp_valid;
  assign bus.cache_addr = cap_addr;
  assign bus.fill_d0    = blk[0];
  assign bus.fill_d1    = blk[1];
  assign bus.fill_d2    = blk[2];
  assign bus.fill_d3    = blk[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat          <= 2'd0;
      cap_addr      <= '0;
      cap_byte      <= 1'b0;
      for (int i = 0; i < 4; i++) blk[i] <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.fill_we   <= 1'b0;
      bus.cache_inv <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.hit_cnt   <= '0;
      bus.miss_cnt  <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.fill_we   <= 1'b0;
      bus.cache_inv <= 1'b0;
      case (state)
        IDLE: begin
          // The rsp_valid cycle still shows the old request, so it is never re-accepted.
          if (bus.req_valid && !bus.rsp_valid) begin
            cap_addr <= bus.req_addr;
            cap_byte <= bus.req_byte;
            if (bus.req_we) begin
              state         <= WRITE;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
              bus.mem_wdata <= bus.req_wdata;
            end else begin
              state <= LOOKUP;
            end
          end
        end
        LOOKUP: begin
          if (bus.cache_hit) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= bus.cache_rdata;
            bus.hit_cnt   <= bus.hit_cnt + CNT_WIDTH'(1);
            state         <= IDLE;
          end else begin
            bus.miss_cnt <= bus.miss_cnt + CNT_WIDTH'(1);
            beat         <= 2'd0;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= {cap_addr[ADDR_WIDTH-1:4], 4'b0000};
            state        <= REFILL;
          end
        end
        REFILL: begin
          if (bus.mem_ready) begin
            blk[beat] <= bus.mem_rdata;
            if (beat == 2'd3) begin
              bus.mem_req <= 1'b0;
              state       <= FILL;
            end else begin
              beat         <= beat + 2'd1;
              bus.mem_addr <= {cap_addr[ADDR_WIDTH-1:4], beat + 2'd1, 2'b00};
            end
          end
        end
        FILL: begin
          bus.fill_we   <= 1'b1;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= cap_byte ? {{(DATA_WIDTH-8){1'b0}}, sel_word[7:0]} : sel_word;
          state         <= IDLE;
        end
        WRITE: begin
          if (bus.mem_ready) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.cache_inv <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - self-checking bench for cache_ctrl with cache, memory and scoreboard models
// A second instance with a 3-bit counter exercises counter wrap in a few cycles.
module tb_cache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  cache_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) bus ();
  cache_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  cache_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(3)) bus2 ();
  cache_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(3)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  assign bus2.req_we      = 1'b0;
  assign bus2.req_byte    = 1'b0;
  assign bus2.req_addr    = 32'h0000_0020;
  assign bus2.req_wdata   = 32'h0;
  assign bus2.cache_hit   = 1'b0;
  assign bus2.cache_rdata = 32'h0;
  assign bus2.mem_ready   = 1'b1;
  assign bus2.mem_rdata   = 32'h0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Environment: backing memory and the cache array, both updated only from DUT outputs.
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [3:0]  c_valid;
  logic [25:0] c_tag  [4];
  logic [31:0] c_data [4][4];
  logic [31:0] c_word;
  bit          cur_byte = 1'b0;

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : (a >> 2);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a >> 2);
  endfunction

  always_comb begin
    c_word          = c_data[bus.cache_addr[5:4]][bus.cache_addr[3:2]];
    bus.cache_hit   = c_valid[bus.cache_addr[5:4]] && (c_tag[bus.cache_addr[5:4]] == bus.cache_addr[31:6]);
    bus.cache_rdata = cur_byte ? {24'h0, c_word[7:0]} : c_word;
  end

  int fixed_lat = 0;
  int lat_sum = 0;
  int fill_cnt = 0, inv_cnt = 0, both_err = 0, hold_err = 0;
  logic [31:0] log_addr[$];
  bit          log_we[$];
  logic [31:0] log_wd[$];
  logic [31:0] fill_w [4];

  initial begin
    bit          in_beat;
    int          cur_lat, waited;
    logic [31:0] h_addr, h_wd;
    bit          h_we;
    logic [1:0]  s;
    in_beat = 0; cur_lat = 1; waited = 0;
    h_addr = 0; h_wd = 0; h_we = 0;
    c_valid = 4'h0;
    for (int i = 0; i < 4; i++) begin
      c_tag[i] = '0;
      for (int j = 0; j < 4; j++) c_data[i][j] = '0;
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (rst) begin
        in_beat = 0;
      end else begin
        s = bus.cache_addr[5:4];
        if (bus.fill_we && bus.cache_inv) both_err++;
        if (bus.fill_we) begin
          fill_cnt++;
          fill_w[0] = bus.fill_d0; fill_w[1] = bus.fill_d1;
          fill_w[2] = bus.fill_d2; fill_w[3] = bus.fill_d3;
          c_valid[s] = 1'b1;
          c_tag[s] = bus.cache_addr[31:6];
          for (int j = 0; j < 4; j++) c_data[s][j] = fill_w[j];
        end
        if (bus.cache_inv) begin
          inv_cnt++;
          c_valid[s] = 1'b0;
        end
        if (bus.mem_req) begin
          if (!in_beat) begin
            in_beat = 1;
            cur_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
            waited = 1;
            h_addr = bus.mem_addr; h_we = bus.mem_we; h_wd = bus.mem_wdata;
          end else begin
            waited++;
            if (bus.mem_addr !== h_addr || bus.mem_we !== h_we || (h_we && bus.mem_wdata !== h_wd))
              hold_err++;
          end
          if (waited >= cur_lat) begin
            bus.mem_ready = 1'b1;
            log_addr.push_back(bus.mem_addr);
            log_we.push_back(bus.mem_we);
            log_wd.push_back(bus.mem_wdata);
            if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata = env_rd(bus.mem_addr);
            lat_sum += cur_lat;
            in_beat = 0;
          end
        end
      end
    end
  end

  // Scoreboard: expected cache contents and counters derived from the access rules.
  bit          ref_valid [4];
  logic [25:0] ref_tag [4];
  logic [15:0] exp_hits = 0, exp_misses = 0;
  int          last_lat;
  logic [31:0] last_rsp;

  task automatic do_access(input string tag, input bit we, input bit byt,
                           input logic [31:0] addr, input logic [31:0] wd);
    logic [1:0]  s;
    logic [25:0] t;
    logic [31:0] word, exp_data, base;
    bit          exp_hit, got;
    int          lat, stall_cnt, f0, i0, exp_lat;
    s = addr[5:4];
    t = addr[31:6];
    base = {addr[31:4], 4'h0};
    exp_hit = !we && ref_valid[s] && (ref_tag[s] == t);
    word = ref_rd({addr[31:2], 2'b00});
    exp_data = byt ? {24'h0, word[7:0]} : word;
    log_addr.delete(); log_we.delete(); log_wd.delete();
    lat_sum = 0; f0 = fill_cnt; i0 = inv_cnt;
    cur_byte = byt;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_byte = byt;
    bus.req_addr = addr; bus.req_wdata = wd;
    lat = 0; stall_cnt = 0; got = 0;
    while (!got && lat < 100) begin
      #1;
      if (bus.rsp_valid) got = 1;
      else begin
        stall_cnt += int'(bus.stall);
        lat++;
        @(negedge clk);
        bus.req_addr = $urandom; bus.req_we = 1'($urandom);
        bus.req_byte = 1'($urandom); bus.req_wdata = $urandom;
      end
    end
    check({tag, "_done"}, 32'(got), 1);
    exp_lat = exp_hit ? 2 : (we ? 1 + lat_sum : 3 + lat_sum);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_stall_cycles"}, stall_cnt, exp_lat);
    check({tag, "_stall_at_rsp"}, 32'(bus.stall), 0);
    if (!we) check({tag, "_rdata"}, bus.rsp_data, exp_data);
    check({tag, "_fill_pulses"}, fill_cnt - f0, (!we && !exp_hit) ? 1 : 0);
    check({tag, "_inv_pulses"}, inv_cnt - i0, we ? 1 : 0);
    if (we) begin
      check({tag, "_wr_beats"}, log_addr.size(), 1);
      if (log_addr.size() == 1) begin
        check({tag, "_wr_addr"}, log_addr[0], {addr[31:2], 2'b00});
        check({tag, "_wr_we"}, 32'(log_we[0]), 1);
        check({tag, "_wr_data"}, log_wd[0], wd);
      end
      ref_valid[s] = 1'b0;
      ref_mem[{addr[31:2], 2'b00}] = wd;
    end else if (exp_hit) begin
      check({tag, "_hit_no_mem"}, log_addr.size(), 0);
      exp_hits++;
    end else begin
      check({tag, "_rd_beats"}, log_addr.size(), 4);
      if (log_addr.size() == 4)
        for (int i = 0; i < 4; i++) begin
          check($sformatf("%s_rd_addr%0d", tag, i), log_addr[i], base + 32'(4 * i));
          check($sformatf("%s_fill_d%0d", tag, i), fill_w[i], ref_rd(base + 32'(4 * i)));
        end
      ref_valid[s] = 1'b1;
      ref_tag[s] = t;
      exp_misses++;
    end
    check({tag, "_hit_cnt"}, bus.hit_cnt, exp_hits);
    check({tag, "_miss_cnt"}, bus.miss_cnt, exp_misses);
    last_lat = lat;
    last_rsp = bus.rsp_data;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, f0;
    for (int i = 0; i < 4; i++) begin ref_valid[i] = 0; ref_tag[i] = '0; end
    bus.req_valid = 0; bus.req_we = 0; bus.req_byte = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus2.req_valid = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", bus.stall, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_fill_we", bus.fill_we, 0);
    check("rst_cache_inv", bus.cache_inv, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_hit_cnt", bus.hit_cnt, 0);
    check("rst_miss_cnt", bus.miss_cnt, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    fixed_lat = 1;
    do_access("cold", 0, 0, 32'h48, 0);
    check("cold_stall7", last_lat, 7);
    check("cold_d0", fill_w[0], 32'h10);
    check("cold_d3", fill_w[3], 32'h13);
    check("cold_rsp", last_rsp, 32'h12);
    do_access("rehit", 0, 0, 32'h48, 0);
    check("rehit_lat2", last_lat, 2);
    check("rehit_rsp", last_rsp, 32'h12);
    fixed_lat = 3;
    do_access("store", 1, 0, 32'h44, 32'hDEAD_BEEF);
    check("store_lat", last_lat, 4);
    check("store_hold", hold_err, 0);
    fixed_lat = 1;
    env_mem[32'h4C] = 32'h1234_56AB;
    ref_mem[32'h4C] = 32'h1234_56AB;
    do_access("byte", 0, 1, 32'h4C, 0);
    check("byte_rsp", last_rsp, 32'h0000_00AB);

    fixed_lat = 2;
    cur_byte = 0;
    bus.req_valid = 1; bus.req_we = 0; bus.req_byte = 0; bus.req_addr = 32'h100;
    n = 0;
    #1;
    while (!(bus.mem_req && bus.mem_addr == 32'h108) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("rst_mid_reach_beat2", 32'(n < 50), 1);
    rst = 1; bus.req_valid = 0;
    f0 = fill_cnt;
    @(negedge clk); #1;
    check("rst_mid_mem_req", bus.mem_req, 0);
    check("rst_mid_stall", bus.stall, 0);
    check("rst_mid_miss_cnt", bus.miss_cnt, 0);
    check("rst_mid_hit_cnt", bus.hit_cnt, 0);
    rst = 0;
    exp_hits = 0; exp_misses = 0;
    repeat (4) @(negedge clk);
    check("rst_mid_no_fill", fill_cnt - f0, 0);
    do_access("restart", 0, 0, 32'h100, 0);

    fixed_lat = 0;
    for (int k = 0; k < 60; k++) begin
      bit we, byt;
      we = ($urandom_range(0, 3) == 0);
      byt = !we && ($urandom_range(0, 2) == 0);
      do_access($sformatf("rnd%0d", k), we, byt, 32'($urandom_range(0, 63)) << 2, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("inv_fill_exclusive", both_err, 0);
    check("mem_hold_all", hold_err, 0);

    rst2 = 0;
    @(negedge clk); #1;
    check("wrap_reset", bus2.miss_cnt, 0);
    bus2.req_valid = 1;
    n = 0; r = 0;
    while (r < 7 && n < 500) begin @(negedge clk); #1; n++; if (bus2.rsp_valid) r++; end
    check("wrap_preload", bus2.miss_cnt, 32'h7);
    while (r < 8 && n < 500) begin @(negedge clk); #1; n++; if (bus2.rsp_valid) r++; end
    check("wrap_zero", bus2.miss_cnt, 0);
    check("wrap_responses", r, 8);
    bus2.req_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
